// File: rtl/niosqs_mem_test_pkg.sv
// Shared definitions for the memory test master: FSM states, command modes
// and the incrementing test pattern.
package niosqs_mem_test_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_t;

   localparam logic [1:0] MODE_NOP   = 2'b00;
   localparam logic [1:0] MODE_FILL  = 2'b01;
   localparam logic [1:0] MODE_CHECK = 2'b10;
   localparam logic [1:0] MODE_BOTH  = 2'b11;

   localparam logic [12:0] ERR_SAT = 13'd4096;

   // Word i of a run carries seed + i, wrapping modulo 2^32.
   function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                                input logic [12:0] idx);
      return seed + {19'd0, idx};
   endfunction

endpackage

// File: rtl/niosqs_mem_test_chk.sv
// Pattern generator for writes and in-order comparator for read responses,
// with sticky error flag, saturating error count and first-fail address.
module niosqs_mem_test_chk
   import niosqs_mem_test_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [31:0] seed,
   input  logic [11:0] base,
   input  logic [12:0] issue_idx,
   output logic [31:0] wr_data,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   output logic        error,
   output logic [12:0] err_count,
   output logic [11:0] err_addr
);

   logic [12:0] ret_idx;
   logic        mismatch;

   assign wr_data  = pattern_word(seed, issue_idx);
   assign mismatch = rsp_valid && (rsp_data != pattern_word(seed, ret_idx));

   // Responses return in issue order, so a private counter tracks which
   // pattern word the next response must match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ret_idx   <= '0;
         error     <= 1'b0;
         err_count <= '0;
         err_addr  <= '0;
      end else if (clear) begin
         ret_idx   <= '0;
         error     <= 1'b0;
         err_count <= '0;
         err_addr  <= '0;
      end else begin
         if (rsp_valid)
            ret_idx <= ret_idx + 13'd1;
         if (mismatch) begin
            error <= 1'b1;
            if (err_count != ERR_SAT)
               err_count <= err_count + 13'd1;
            if (!error)
               err_addr <= base + ret_idx[11:0];
         end
      end
   end

endmodule

// File: rtl/niosqs_mem_test_master.sv
// Avalon-MM memory test master: fills a word window with an incrementing
// pattern and/or reads it back with up to MAX_PEND pipelined reads.
module niosqs_mem_test_master
   import niosqs_mem_test_pkg::*;
#(
   parameter int ADDR_W   = 14,
   parameter int MAX_PEND = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [11:0]       base,
   input  logic [12:0]       count,
   input  logic [31:0]       seed,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [12:0]       err_count,
   output logic [11:0]       err_addr,
   output logic [ADDR_W-1:0] avm_address,
   output logic [3:0]        avm_byteenable,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid
);

   localparam logic [3:0] PEND_LIM = 4'(MAX_PEND);

   state_t      state, state_nxt;
   logic [11:0] base_r;
   logic [12:0] count_r;
   logic [31:0] seed_r;
   logic        check_after;
   logic [12:0] issue_idx, issue_idx_nxt;
   logic [3:0]  pending;
   logic        accept_start, last_xfer, rd_accept, rsp_valid;
   logic [11:0] word_idx;
   logic [13:0] byte_addr;

   assign accept_start   = (state == IDLE) && start;
   assign last_xfer      = ((issue_idx + 13'd1) == count_r);
   assign rd_accept      = avm_read && !avm_waitrequest;
   assign rsp_valid      = avm_readdatavalid && (pending != 4'd0);
   assign word_idx       = base_r + issue_idx[11:0];
   assign byte_addr      = {word_idx, 2'b00};
   assign avm_address    = ADDR_W'(byte_addr);
   assign avm_byteenable = 4'hF;
   assign busy           = (state != IDLE);
   assign done           = (state == DONE);

   // Command outputs are decoded from registers that only move on a
   // completed transfer, so they stay put while the slave stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         issue_idx   <= '0;
         pending     <= '0;
         base_r      <= '0;
         count_r     <= '0;
         seed_r      <= '0;
         check_after <= 1'b0;
      end else begin
         state     <= state_nxt;
         issue_idx <= issue_idx_nxt;
         if (accept_start) begin
            base_r      <= base;
            count_r     <= count;
            seed_r      <= seed;
            check_after <= mode[1];
         end
         case ({rd_accept, rsp_valid})
            2'b10:   pending <= pending + 4'd1;
            2'b01:   pending <= pending - 4'd1;
            default: pending <= pending;
         endcase
      end
   end

   always_comb begin
      state_nxt     = state;
      issue_idx_nxt = issue_idx;
      avm_read      = 1'b0;
      avm_write     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               issue_idx_nxt = '0;
               if (mode == MODE_NOP || count == 13'd0)
                  state_nxt = DONE;
               else if (mode[0])
                  state_nxt = WRITE;
               else
                  state_nxt = READ;
            end
         end
         WRITE: begin
            avm_write = 1'b1;
            if (!avm_waitrequest) begin
               if (last_xfer) begin
                  issue_idx_nxt = '0;
                  state_nxt     = check_after ? READ : DONE;
               end else begin
                  issue_idx_nxt = issue_idx + 13'd1;
               end
            end
         end
         READ: begin
            avm_read = (pending < PEND_LIM);
            if (avm_read && !avm_waitrequest) begin
               issue_idx_nxt = issue_idx + 13'd1;
               if (last_xfer)
                  state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pending == 4'd0)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   niosqs_mem_test_chk u_chk (
      .clk       (clk),
      .reset     (reset),
      .clear     (accept_start),
      .seed      (seed_r),
      .base      (base_r),
      .issue_idx (issue_idx),
      .wr_data   (avm_writedata),
      .rsp_valid (rsp_valid),
      .rsp_data  (avm_readdata),
      .error     (error),
      .err_count (err_count),
      .err_addr  (err_addr)
   );

endmodule

// File: doc/niosqs_mem_test_master.md
NIOSQS_MEM_TEST_MASTER -- requirements
Module: niosqs_mem_test_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning Avalon byte-address width (16 KB window).
REQ-002 SHALL have parameter MAX_PEND, default 4, meaning maximum outstanding reads (1..8).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic in this clock domain.
REQ-004 SHALL have port reset, input, 1, meaning reset: asynchronous assert, active-high.
REQ-005 SHALL have port start, input, 1, meaning command strobe, sampled only in IDLE.
REQ-006 SHALL have port mode, input, 2, meaning 01 fill, 10 check, 11 fill-then-check, 00 no-op.
REQ-007 SHALL have port base, input, 12, meaning first word index.
REQ-008 SHALL have port count, input, 13, meaning words to process, 0..4096.
REQ-009 SHALL have port seed, input, 32, meaning pattern seed.
REQ-010 SHALL have port busy, input/output roles as follows: busy output 1 (high outside IDLE); done output 1 (one-cycle pulse); error output 1 (sticky); err_count output 13; err_addr output 12 (first mismatching word index).
REQ-011 SHALL have Avalon-MM master ports: avm_address out ADDR_W; avm_byteenable out 4; avm_read out 1; avm_write out 1; avm_writedata out 32; avm_waitrequest in 1; avm_readdata in 32; avm_readdatavalid in 1.

Function
REQ-012 SHALL use pattern word i = seed + i (mod 2^32), i = 0..count-1.
REQ-013 SHALL form avm_address = {(base + i) mod 4096, 2'b00}; word index wraps 4095 -> 0.
REQ-014 SHALL drive avm_byteenable = 4'hF constantly.
REQ-015 SHALL implement FSM states IDLE, WRITE, READ, DRAIN, DONE.
REQ-016 SHALL latch base, count, seed and mode on start in IDLE; start outside IDLE ignored.
REQ-017 SHALL go IDLE -> WRITE for mode 01/11, IDLE -> READ for mode 10, IDLE -> DONE for mode 00 or count 0.
REQ-018 SHALL hold avm_address, avm_writedata, avm_read and avm_write stable while avm_waitrequest is high; a transfer completes on a cycle with the command asserted and waitrequest low.
REQ-019 SHALL advance the issue index only on completed transfers; never assert avm_read and avm_write together.
REQ-020 SHALL go WRITE -> READ (mode 11) or WRITE -> DONE (mode 01) the cycle after the last write completes.
REQ-021 SHALL issue a read only when pending < MAX_PEND; pending +1 on read acceptance, -1 on readdatavalid, both in the same cycle leaving it unchanged.
REQ-022 SHALL go READ -> DRAIN after the last read is accepted, and DRAIN -> DONE when pending = 0.
REQ-023 SHALL, on each readdatavalid, compare readdata with the pattern of a separate return index (responses arrive in order), then increment the return index.
REQ-024 SHALL, on mismatch, set error; increment err_count (saturating at 4096); capture err_addr only on the first mismatch of a command.
REQ-025 SHALL ignore readdatavalid while pending = 0.
REQ-026 SHALL pulse done for exactly one cycle in DONE, then return to IDLE.
REQ-027 SHALL clear error, err_count and err_addr on accepted start.

Reset
REQ-028 SHALL, on reset assertion, immediately force IDLE, avm_read = 0, avm_write = 0, busy = 0, done = 0, error = 0, err_count = 0, err_addr = 0, avm_address = 0, avm_writedata = 0, pending = 0.
REQ-029 SHALL abandon any command on reset mid-operation; late readdatavalid after reset is ignored under REQ-025.

Structure
REQ-030 SHALL place FSM state enumeration, mode encodings and the pattern function in shared package niosqs_mem_test_pkg.
REQ-031 SHALL implement the pattern generator/comparator as sub-module niosqs_mem_test_chk; the rest is flat.

Verification
REQ-032 SHALL test fill: mode 01, base 0, count 4, seed 0x1000, no waitrequest -> 4 writes of 0x1000..0x1003 to byte addresses 0x0,0x4,0x8,0xC, done 1 cycle after the last write.
REQ-033 SHALL test check with 1-cycle-latency memory model preloaded: mode 11, base 0xFFE, count 4, seed 0 -> addresses wrap 0x3FF8,0x3FFC,0x0,0x4; error = 0, err_count = 0.
REQ-034 SHALL test an injected fault: corrupt word 2 of REQ-032 region before mode 10 -> error = 1, err_count = 1, err_addr = 0x002.
REQ-035 SHALL test waitrequest held 3 cycles on every transfer -> command signals stable throughout, no duplicate or dropped transfers.
REQ-036 SHALL test readdatavalid delayed 10 cycles, MAX_PEND 4, count 8 -> never more than 4 reads outstanding, correct compare.
REQ-037 SHALL test reset asserted mid-READ -> avm_read low the same cycle, busy 0, error cleared.
